fifo_write_arbiter: RTL
=======================

Name: fifo_write_arbiter

Overview:
- Shares the single write port of the asynchronous FIFO (din_clka / wr_en_clka / full_clka, clka domain) among NUM_REQ requesters.
- Round-robin arbitration with bounded bursts; the granted requester streams words until it drops its request or reaches MAX_BURST.
- Sits entirely in the clka domain, directly in front of the FIFO write side.
- Never writes while full_clka=1, so no word is lost on the FIFO side.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, word width; matches FIFO din width.
- MAX_BURST, 8, maximum words per grant (1..255).

Ports:
- clka  in  1  write-side clock.
- resetb_clka  in  1  asynchronous active-low reset.
- req_clka  in  NUM_REQ  per-requester "word available"; bit i held high while requester i has data.
- data_clka  in  NUM_REQ*DATA_W  requester i word on bits [i*DATA_W +: DATA_W].
- gnt_clka  out  NUM_REQ  registered one-hot grant; all-zero when idle.
- accept_clka  out  NUM_REQ  combinational per-requester pulse; word taken this cycle, so the requester advances its data.
- din_clka  out  DATA_W  to FIFO; combinational mux of granted requester data.
- wr_en_clka  out  1  to FIFO write enable; combinational.
- full_clka  in  1  FIFO full flag.

Behaviour:
- Reset (async assert, sync release on clka) sets:
  - state=IDLE, gnt_clka=0, rr_ptr=0, burst_cnt=0.
  - Combinational outputs therefore read accept_clka=0, wr_en_clka=0 and din_clka=0, since the mux output is 0 when no grant.
- Accept rule: accept_clka[i] = gnt_clka[i] & req_clka[i] & ~full_clka. wr_en_clka = |accept_clka. din_clka = data of the granted index, or 0 if none.
- State IDLE:
  - If any req_clka bit is set, register a grant to the first set bit searching upward from rr_ptr with wrap.
  - Go to BURST and clear burst_cnt.
  - Latency: req rising at edge n gives gnt at edge n+1; the first word can be written in the cycle after edge n+1.
- State BURST:
  - On each accept, burst_cnt increments.
  - End of burst occurs on a cycle where either:
    - req of the granted requester is low, or
    - an accept occurs with burst_cnt == MAX_BURST-1.
  - At end of burst:
    - rr_ptr <= winner+1 (mod NUM_REQ).
    - Re-arbitrate in the same cycle over current req_clka, searching from winner+1. The previous winner is eligible, but only if no other requester is set.
    - If a winner exists, register the new grant and stay in BURST with burst_cnt=0 (no idle bubble). Otherwise go to IDLE with gnt_clka=0.
- full_clka=1 while granted: grant held, no accept, burst_cnt frozen; resumes when full deasserts.
- Requester dropping req mid-burst counts as end of burst even if full_clka=1.
- Grant never changes except at end of burst or reset; no preemption.
- Reset mid-burst: grant removed immediately and asynchronously; no partial word is written after reset asserts.
- MAX_BURST=1: every accepted word ends the burst, giving pure word-level round-robin.

Optional Feature:
- Macro: FIFO_WRITE_ARB_STATS_EN.
- With the macro defined:
  - Adds output stat_words_clka (NUM_REQ*16): per-requester 16-bit count of accepted words, saturating at 0xFFFF.
  - Adds output stat_full_stall_clka (16): count of cycles with a grant active and full_clka=1, saturating.
  - All counters reset to 0.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single requester: req_clka=4'b0001 steady, data incrementing 0..19, full_clka=0 → gnt at cycle after req; wr_en high except a one-cycle regrant gap after every 8 words? No: it is immediately regranted, so all 20 words arrive in order 0..19 with no bubble.
- All four requesting continuously, MAX_BURST=8 → grant order 0,1,2,3,0; each burst exactly 8 accepts; no cycle has two gnt bits set.
- full_clka forced high for 5 cycles mid-burst of requester 1 → wr_en_clka=0 for those 5 cycles, gnt_clka stays 4'b0010, burst resumes and totals exactly 8 words.
- Requester 2 drops req after 3 words while requester 3 requests → gnt moves to 4'b1000 the next cycle; rr_ptr=3.
- resetb_clka pulsed low mid-burst → gnt_clka, wr_en_clka and accept_clka go to 0 immediately; after release, arbitration restarts from requester 0.
- With FIFO_WRITE_ARB_STATS_EN: run the second scenario for 64 cycles → stat_words_clka equals the per-requester accept counts checked by a scoreboard, and the end-to-end FIFO read data order matches the scoreboard order.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: shares the clka-domain write port of the async FIFO
// among NUM_REQ requesters. Round-robin grants with bursts bounded by
// MAX_BURST. Writes are suppressed while full_clka is high.
// Optional feature macro: FIFO_WRITE_ARB_STATS_EN (per-requester word
// counters and a full-stall cycle counter, all saturating at 0xFFFF).
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no grant held; arbitrate from rr_ptr when any req is set
// ST_BURST| one requester granted; streams until req drops or MAX_BURST
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                      clka,
    input  logic                      resetb_clka,
    input  logic [NUM_REQ-1:0]        req_clka,
    input  logic [NUM_REQ*DATA_W-1:0] data_clka,
    output logic [NUM_REQ-1:0]        gnt_clka,
    output logic [NUM_REQ-1:0]        accept_clka,
    output logic [DATA_W-1:0]         din_clka,
    output logic                      wr_en_clka,
    input  logic                      full_clka
`ifdef FIFO_WRITE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     stat_words_clka,
    output logic [15:0]               stat_full_stall_clka
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 8;

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

    logic [IDX_W-1:0]   nxt_ptr;
    logic               end_burst;
    logic [IDX_W:0]     pick;

    // First set request at or above start, wrapping; MSB flags "found".
    // Scanning k downward lets the closest candidate overwrite farther ones.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   start);
        logic [IDX_W:0]     res;
        logic [NUM_REQ-1:0] tmp;
        int                 j;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j   = (int'(start) + k) % NUM_REQ;
            tmp = req >> j;
            if (tmp[0]) res = {1'b1, IDX_W'(j)};
        end
        return res;
    endfunction

    // Write-side outputs: accept only when granted, requesting and not full.
    always_comb begin
        accept_clka = gnt_q & req_clka & {NUM_REQ{~full_clka}};
        wr_en_clka  = |accept_clka;
        din_clka    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) din_clka = data_clka[i*DATA_W +: DATA_W];
        end
    end

    assign gnt_clka = gnt_q;

    // Next-state: arbitration, burst counting and back-to-back regrant.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        win_d       = win_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        pick        = '0;
        nxt_ptr     = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        end_burst   = ~|(gnt_q & req_clka) |
                      (wr_en_clka & (burst_cnt_q == CNT_W'(MAX_BURST - 1)));
        case (state_q)
            ST_IDLE: begin
                pick = rr_pick(req_clka, rr_ptr_q);
                if (pick[IDX_W]) begin
                    gnt_d       = NUM_REQ'(1) << pick[IDX_W-1:0];
                    win_d       = pick[IDX_W-1:0];
                    burst_cnt_d = '0;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                if (wr_en_clka) burst_cnt_d = burst_cnt_q + 1'b1;
                if (end_burst) begin
                    // Searching from winner+1 leaves the old winner last in line.
                    rr_ptr_d    = nxt_ptr;
                    burst_cnt_d = '0;
                    pick        = rr_pick(req_clka, nxt_ptr);
                    if (pick[IDX_W]) begin
                        gnt_d = NUM_REQ'(1) << pick[IDX_W-1:0];
                        win_d = pick[IDX_W-1:0];
                    end else begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset drops the grant immediately.
    always_ff @(posedge clka or negedge resetb_clka) begin
        if (!resetb_clka) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            win_q       <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            win_q       <= win_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef FIFO_WRITE_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] stat_words_q;
    logic [15:0]              stat_stall_q;

    assign stat_words_clka      = stat_words_q;
    assign stat_full_stall_clka = stat_stall_q;

    // Saturating statistics counters.
    always_ff @(posedge clka or negedge resetb_clka) begin
        if (!resetb_clka) begin
            stat_words_q <= '0;
            stat_stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept_clka[i] && (stat_words_q[i] != 16'hFFFF))
                    stat_words_q[i] <= stat_words_q[i] + 16'd1;
            end
            if ((|gnt_q) && full_clka && (stat_stall_q != 16'hFFFF))
                stat_stall_q <= stat_stall_q + 16'd1;
        end
    end
`endif

endmodule
